// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the AHB-to-APB bridge slave side.
//   HTRANS_* : AHB transfer type encodings
//   HRESP_*  : AHB response encodings (OKAY / ERROR)
//   resp_state_e : states of the two-cycle ERROR response FSM
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    StOkay = 2'b00,
    StErr1 = 2'b01,
    StErr2 = 2'b10
  } resp_state_e;

endpackage

// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master side and the bridge slave interface.
//   master-driven : hwrite, hready_in, htrans, haddr, hwdata
//   APB-ctl driven: prdata, apb_ready
//   slave-driven  : valid, haddr_1/2, hwdata_1/2, hwrite_reg/_1, tempselx, hrdata, hresp,
//                   hready_out
// modport slave is used by ahb_slave_if; modport master by whatever drives the bus.
interface ahb_slave_if_if;

  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        apb_ready;

  logic        valid;
  logic [31:0] haddr_1;
  logic [31:0] haddr_2;
  logic [31:0] hwdata_1;
  logic [31:0] hwdata_2;
  logic        hwrite_reg;
  logic        hwrite_reg_1;
  logic [2:0]  tempselx;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hready_out;

  modport slave (
    input  hwrite, hready_in, htrans, haddr, hwdata, prdata, apb_ready,
    output valid, haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg_1,
           tempselx, hrdata, hresp, hready_out
  );

  modport master (
    output hwrite, hready_in, htrans, haddr, hwdata, prdata, apb_ready,
    input  valid, haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg_1,
           tempselx, hrdata, hresp, hready_out
  );

endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder for the three APB peripheral regions.
//   haddr    : AHB address
//   in_win   : haddr lies inside [BASE_ADDR, BASE_ADDR + 3*REGION_SZ)
//   tempselx : one-hot region select (001/010/100), 000 outside the window
module ahb_addr_decode #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] REGION_SZ = 32'h0400_0000
) (
  input  logic [31:0] haddr,
  output logic        in_win,
  output logic [2:0]  tempselx
);

  // Boundaries held in 33 bits so a window ending exactly at 2^32 is representable.
  localparam logic [32:0] Region1Start = {1'b0, REGION_SZ};
  localparam logic [32:0] Region2Start = 33'(2) * {1'b0, REGION_SZ};
  localparam logic [32:0] WinEnd       = {1'b0, BASE_ADDR} + 33'(3) * {1'b0, REGION_SZ};

  if (WinEnd > 33'h1_0000_0000) begin : g_window_overflow
    $error("ahb_addr_decode: BASE_ADDR + 3*REGION_SZ exceeds the 32-bit address space");
  end

  logic [31:0] offset;

  always_comb begin
    offset   = haddr - BASE_ADDR;
    in_win   = (haddr >= BASE_ADDR) && ({1'b0, haddr} < WinEnd);
    tempselx = 3'b000;
    if (in_win) begin
      if ({1'b0, offset} < Region1Start) begin
        tempselx = 3'b001;
      end else if ({1'b0, offset} < Region2Start) begin
        tempselx = 3'b010;
      end else begin
        tempselx = 3'b100;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side slave interface of the AHB-to-APB bridge.
//   hclk   : system clock, rising edge
//   hreset : asynchronous, active-high reset
//   bus    : ahb_slave_if_if.slave -- AHB inputs, APB controller handshake, registered
//            address/data/control pipeline, region select, HRDATA/HRESP/HREADY outputs
// Holds the two-deep pipeline registers and the OKAY/ERR1/ERR2 response FSM that produces
// the two-cycle AHB ERROR response for out-of-window accesses.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] REGION_SZ = 32'h0400_0000
) (
  input logic          hclk,
  input logic          hreset,
  ahb_slave_if_if.slave bus
);

  logic        in_win;
  logic        active;
  resp_state_e state_q, state_d;

  ahb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .REGION_SZ (REGION_SZ)
  ) u_addr_decode (
    .haddr    (bus.haddr),
    .in_win   (in_win),
    .tempselx (bus.tempselx)
  );

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY never start a transfer.
  assign active     = bus.hready_in && bus.htrans[1];
  assign bus.valid  = active && in_win && (state_q == StOkay);
  assign bus.hrdata = bus.prdata;

  // Pipeline advances only on accepted cycles; error beats are captured too (harmless).
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      bus.haddr_1      <= '0;
      bus.haddr_2      <= '0;
      bus.hwdata_1     <= '0;
      bus.hwdata_2     <= '0;
      bus.hwrite_reg   <= 1'b0;
      bus.hwrite_reg_1 <= 1'b0;
    end else if (bus.hready_in) begin
      bus.haddr_1      <= bus.haddr;
      bus.haddr_2      <= bus.haddr_1;
      bus.hwdata_1     <= bus.hwdata;
      bus.hwdata_2     <= bus.hwdata_1;
      bus.hwrite_reg   <= bus.hwrite;
      bus.hwrite_reg_1 <= bus.hwrite_reg;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= StOkay;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.hresp      = HRESP_OKAY;
    bus.hready_out = 1'b1;
    unique case (state_q)
      StOkay: begin
        bus.hready_out = bus.apb_ready;
        if (active && !in_win) begin
          state_d = StErr1;
        end
      end
      StErr1: begin
        bus.hresp      = HRESP_ERROR;
        bus.hready_out = 1'b0;
        state_d        = StErr2;
      end
      StErr2: begin
        // Any transfer presented here is dropped; the master reissues after ERROR.
        bus.hresp      = HRESP_ERROR;
        bus.hready_out = 1'b1;
        state_d        = StOkay;
      end
      default: begin
        state_d = StOkay;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if: expected values are queued when stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_ahb_slave_if;

  logic hclk;
  logic hreset;

  ahb_slave_if_if bus ();

  ahb_slave_if #(
    .BASE_ADDR (32'h8000_0000),
    .REGION_SZ (32'h0400_0000)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Pipeline model for the burst test.
  logic [31:0] m_a1, m_a2;

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
    bus.htrans = tr;
    bus.haddr  = a;
    bus.hwrite = w;
  endtask

  logic [1:0]  b_tr [5];
  logic [31:0] b_ad [5];

  initial begin
    hreset        = 1'b1;
    bus.hwrite    = 1'b0;
    bus.hready_in = 1'b1;
    bus.htrans    = 2'b00;
    bus.haddr     = '0;
    bus.hwdata    = '0;
    bus.prdata    = '0;
    bus.apb_ready = 1'b1;
    tick();
    tick();

    // Reset state
    push(32'h0); push(32'h0); push(32'h0); push(32'h1);
    chk("rst_haddr_1", bus.haddr_1);
    chk("rst_hwdata_2", bus.hwdata_2);
    chk("rst_hresp", {30'h0, bus.hresp});
    chk("rst_hready_out", {31'h0, bus.hready_out});
    hreset = 1'b0;
    tick();

    // 1: single write
    drive(2'b10, 32'h8842_C0A6, 1'b1);
    push(32'h1); push(32'h4);
    #1;
    chk("t1_valid", {31'h0, bus.valid});
    chk("t1_tempselx", {29'h0, bus.tempselx});
    tick();
    push(32'h8842_C0A6); push(32'h1);
    chk("t1_haddr_1", bus.haddr_1);
    chk("t1_hwrite_reg", {31'h0, bus.hwrite_reg});
    drive(2'b00, 32'h0, 1'b0);
    bus.hwdata = 32'hDEAD_BEEF;
    tick();
    push(32'hDEAD_BEEF); push(32'h0); push(32'h8842_C0A6);
    chk("t1_hwdata_1", bus.hwdata_1);
    chk("t1_hresp", {30'h0, bus.hresp});
    chk("t1_haddr_2", bus.haddr_2);

    // 2: single read
    drive(2'b10, 32'h8400_B866, 1'b0);
    bus.prdata = 32'h1234_5678;
    push(32'h2); push(32'h1234_5678); push(32'h1);
    #1;
    chk("t2_tempselx", {29'h0, bus.tempselx});
    chk("t2_hrdata", bus.hrdata);
    chk("t2_valid", {31'h0, bus.valid});
    tick();
    drive(2'b00, 32'h0, 1'b0);
    tick();

    // 3: INCR4 with a BUSY beat
    b_tr = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
    b_ad = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    m_a1 = bus.haddr_1;
    m_a2 = bus.haddr_2;
    for (int i = 0; i < 5; i++) begin
      drive(b_tr[i], b_ad[i], 1'b1);
      bus.hwdata = 32'hA000_0000 + 32'(i);
      push((b_tr[i] == 2'b01) ? 32'h0 : 32'h1);
      #1;
      chk("t3_valid", {31'h0, bus.valid});
      tick();
      m_a2 = m_a1;
      m_a1 = b_ad[i];
      push(m_a2);
      chk("t3_haddr_2", bus.haddr_2);
    end
    bus.hready_in = 1'b0;
    drive(2'b11, 32'h8000_0010, 1'b0);
    bus.hwdata = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      push(32'h0);
      #1;
      chk("t3_stall_valid", {31'h0, bus.valid});
      tick();
      push(m_a1); push(m_a2); push(32'hA000_0004);
      chk("t3_hold_haddr_1", bus.haddr_1);
      chk("t3_hold_haddr_2", bus.haddr_2);
      chk("t3_hold_hwdata_1", bus.hwdata_1);
    end
    bus.hready_in = 1'b1;
    drive(2'b00, 32'h0, 1'b0);
    tick();

    // 4: out-of-window access, then window top edge
    drive(2'b10, 32'h8C00_0000, 1'b0);
    push(32'h0); push(32'h0);
    #1;
    chk("t4_err_valid", {31'h0, bus.valid});
    chk("t4_err_tempselx", {29'h0, bus.tempselx});
    tick();
    drive(2'b00, 32'h0, 1'b0);
    push(32'h1); push(32'h0);
    chk("t4_err1_hresp", {30'h0, bus.hresp});
    chk("t4_err1_hready", {31'h0, bus.hready_out});
    tick();
    push(32'h1); push(32'h1);
    chk("t4_err2_hresp", {30'h0, bus.hresp});
    chk("t4_err2_hready", {31'h0, bus.hready_out});
    tick();
    push(32'h0); push(32'h1);
    chk("t4_okay_hresp", {30'h0, bus.hresp});
    chk("t4_okay_hready", {31'h0, bus.hready_out});
    drive(2'b10, 32'h8BFF_FFFF, 1'b0);
    push(32'h1); push(32'h4);
    #1;
    chk("t4_top_valid", {31'h0, bus.valid});
    chk("t4_top_tempselx", {29'h0, bus.tempselx});
    tick();
    drive(2'b00, 32'h0, 1'b0);
    push(32'h0);
    chk("t4_top_hresp", {30'h0, bus.hresp});
    tick();

    // 5: APB stall mid-burst
    drive(2'b10, 32'h8000_0100, 1'b1);
    tick();
    drive(2'b11, 32'h8000_0104, 1'b1);
    bus.apb_ready = 1'b0;
    bus.hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h0); push(32'h0);
      #1;
      chk("t5_stall_hready", {31'h0, bus.hready_out});
      chk("t5_stall_hresp", {30'h0, bus.hresp});
      tick();
    end
    bus.apb_ready = 1'b1;
    bus.hready_in = 1'b1;
    push(32'h1);
    #1;
    chk("t5_resume_hready", {31'h0, bus.hready_out});
    tick();
    drive(2'b00, 32'h0, 1'b0);
    tick();

    // 6: reset during ERR1
    drive(2'b10, 32'h9000_0000, 1'b1);
    bus.hwdata = 32'h0BAD_F00D;
    tick();
    drive(2'b00, 32'h0, 1'b0);
    push(32'h1); push(32'h0);
    chk("t6_err1_hresp", {30'h0, bus.hresp});
    chk("t6_err1_hready", {31'h0, bus.hready_out});
    hreset = 1'b1;
    push(32'h0); push(32'h1); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    #1;
    chk("t6_rst_hresp", {30'h0, bus.hresp});
    chk("t6_rst_hready", {31'h0, bus.hready_out});
    chk("t6_rst_haddr_1", bus.haddr_1);
    chk("t6_rst_haddr_2", bus.haddr_2);
    chk("t6_rst_hwdata_1", bus.hwdata_1);
    chk("t6_rst_hwrite_reg", {31'h0, bus.hwrite_reg});
    tick();
    hreset = 1'b0;
    tick();

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
